// File: rtl/game_pkg.sv
// Shared game constants, the packed sprite position type and the bullet FSM state type.
// Imported by every game-logic block so sprite geometry stays consistent.
package game_pkg;

    localparam int unsigned MAX_ENEMY         = 8;
    localparam int unsigned MAX_ENEMY_BULLET  = 8;
    localparam int unsigned MAX_PLAYER_BULLET = 15;

    localparam logic [9:0] PLAYER_WIDTH  = 10'd24;
    localparam logic [8:0] PLAYER_HEIGHT = 9'd24;
    localparam logic [9:0] ENEMY_WIDTH   = 10'd24;
    localparam logic [8:0] ENEMY_HEIGHT  = 9'd16;
    localparam logic [9:0] BULLET_WIDTH  = 10'd4;
    localparam logic [8:0] BULLET_HEIGHT = 9'd16;

    localparam logic [8:0]  PLAYER_Y = 9'd420;
    localparam logic [18:0] NONE     = {19{1'b1}};

    // {x[18:9], y[8:0]}
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        StIdle,
        StMerge,
        StMove,
        StSpawn
    } pb_state_e;

endpackage

// File: rtl/player_bullet_controller_if.sv
// Frame-update bundle between the player bullet controller and its neighbours
// (frame timing, player inputs, collision feedback and the registered bullet arrays).
interface player_bullet_controller_if #(
    parameter int unsigned N = game_pkg::MAX_PLAYER_BULLET
);
    import game_pkg::*;

    logic           i_FrameTick;
    logic           i_Fire;
    logic           i_PlayerState;
    logic [9:0]     i_PlayerPosition;
    logic [N-1:0]   i_CollidedState;
    logic [N-1:0]   o_PlayerBulletState;
    pos_t [N-1:0]   o_PlayerBulletPosition;
    logic           o_Busy;
    logic           o_Fired;

    modport master (
        output i_FrameTick, i_Fire, i_PlayerState, i_PlayerPosition, i_CollidedState,
        input  o_PlayerBulletState, o_PlayerBulletPosition, o_Busy, o_Fired
    );

    modport slave (
        input  i_FrameTick, i_Fire, i_PlayerState, i_PlayerPosition, i_CollidedState,
        output o_PlayerBulletState, o_PlayerBulletPosition, o_Busy, o_Fired
    );

endinterface

// File: rtl/slot_allocator.sv
// Combinational lowest-index free-slot finder for the bullet pool.
module slot_allocator #(
    parameter int unsigned N = 15
) (
    input  logic [N-1:0] i_State,
    output logic         o_Found,
    output logic [3:0]   o_Index
);

    // Scan downwards so the last hit, the lowest free index, wins.
    always_comb begin
        o_Found = 1'b0;
        o_Index = 4'd0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!i_State[i]) begin
                o_Found = 1'b1;
                o_Index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/player_bullet_controller.sv
// Per-frame manager of the player bullet pool: merges collision survivors, moves each live
// bullet upward one slot per cycle, then spawns at most one new bullet at the muzzle.
module player_bullet_controller
    import game_pkg::*;
#(
    parameter int unsigned MAX_PLAYER_BULLET = game_pkg::MAX_PLAYER_BULLET,
    parameter logic [9:0]  BULLET_WIDTH      = 10'd4,
    parameter logic [8:0]  BULLET_HEIGHT     = 9'd16,
    parameter logic [9:0]  PLAYER_WIDTH      = 10'd24,
    parameter logic [8:0]  PLAYER_Y          = 9'd420,
    parameter logic [8:0]  BULLET_SPEED      = 9'd4,
    parameter logic [3:0]  FIRE_COOLDOWN     = 4'd8,
    parameter logic [18:0] NONE              = {19{1'b1}}
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    player_bullet_controller_if.slave  bus
);

    localparam logic [9:0] SPAWN_X_OFF = (PLAYER_WIDTH - BULLET_WIDTH) >> 1;
    localparam logic [8:0] SPAWN_Y     = PLAYER_Y - BULLET_HEIGHT;
    localparam logic [3:0] LAST_IDX    = 4'(MAX_PLAYER_BULLET - 1);

    logic [1:0]                   r_RstSync;
    logic                         w_RstN;
    pb_state_e                    r_State, w_StateNext;
    logic [MAX_PLAYER_BULLET-1:0] r_Live, w_LiveNext;
    pos_t [MAX_PLAYER_BULLET-1:0] r_Pos, w_PosNext;
    logic [3:0]                   r_Cooldown, w_CooldownNext;
    logic [3:0]                   r_Idx, w_IdxNext;
    logic                         w_Found;
    logic [3:0]                   w_FreeIdx;
    logic                         w_SpawnOk;
    logic                         w_Fired;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_RstSync <= 2'b00;
        else          r_RstSync <= {r_RstSync[0], 1'b1};
    end
    assign w_RstN = r_RstSync[1];

    slot_allocator #(
        .N (MAX_PLAYER_BULLET)
    ) u_slot_allocator (
        .i_State (r_Live),
        .o_Found (w_Found),
        .o_Index (w_FreeIdx)
    );

    assign w_SpawnOk = bus.i_Fire & bus.i_PlayerState & (r_Cooldown == 4'd0) & w_Found;

    always_ff @(posedge i_Clk or negedge w_RstN) begin
        if (!w_RstN) begin
            r_State    <= StIdle;
            r_Live     <= '0;
            r_Pos      <= {MAX_PLAYER_BULLET{pos_t'(NONE)}};
            r_Cooldown <= 4'd0;
            r_Idx      <= 4'd0;
        end else begin
            r_State    <= w_StateNext;
            r_Live     <= w_LiveNext;
            r_Pos      <= w_PosNext;
            r_Cooldown <= w_CooldownNext;
            r_Idx      <= w_IdxNext;
        end
    end

    always_comb begin
        w_StateNext    = r_State;
        w_LiveNext     = r_Live;
        w_PosNext      = r_Pos;
        w_CooldownNext = r_Cooldown;
        w_IdxNext      = r_Idx;
        w_Fired        = 1'b0;
        unique case (r_State)
            StIdle: begin
                if (bus.i_FrameTick) w_StateNext = StMerge;
            end
            StMerge: begin
                w_LiveNext = r_Live & bus.i_CollidedState;
                for (int i = 0; i < int'(MAX_PLAYER_BULLET); i++) begin
                    if (!w_LiveNext[i]) w_PosNext[i] = pos_t'(NONE);
                end
                if (r_Cooldown != 4'd0) w_CooldownNext = r_Cooldown - 4'd1;
                w_IdxNext   = 4'd0;
                w_StateNext = StMove;
            end
            StMove: begin
                if (r_Live[r_Idx]) begin
                    // Retire before subtracting so y can never wrap.
                    if (r_Pos[r_Idx].y < BULLET_SPEED) begin
                        w_LiveNext[r_Idx] = 1'b0;
                        w_PosNext[r_Idx]  = pos_t'(NONE);
                    end else begin
                        w_PosNext[r_Idx].y = r_Pos[r_Idx].y - BULLET_SPEED;
                    end
                end
                if (r_Idx == LAST_IDX) w_StateNext = StSpawn;
                else                   w_IdxNext   = r_Idx + 4'd1;
            end
            StSpawn: begin
                if (w_SpawnOk) begin
                    w_LiveNext[w_FreeIdx]  = 1'b1;
                    w_PosNext[w_FreeIdx].x = bus.i_PlayerPosition + SPAWN_X_OFF;
                    w_PosNext[w_FreeIdx].y = SPAWN_Y;
                    w_CooldownNext         = FIRE_COOLDOWN;
                    w_Fired                = 1'b1;
                end
                w_StateNext = StIdle;
            end
            default: w_StateNext = StIdle;
        endcase
    end

    assign bus.o_PlayerBulletState    = r_Live;
    assign bus.o_PlayerBulletPosition = r_Pos;
    assign bus.o_Busy                 = (r_State != StIdle);
    assign bus.o_Fired                = w_Fired;

endmodule

// File: tb/tb_player_bullet_controller.sv
// Randomised and directed frame-level checks of the bullet controller against a slot-list model;
// a second instance with a short cooldown is used to reach a full pool.
module tb_player_bullet_controller;
    import game_pkg::*;

    localparam int N       = 15;
    localparam int PW      = 19;
    localparam int SPAWN_Y = int'(PLAYER_Y) - int'(BULLET_HEIGHT);
    localparam int X_OFF   = (int'(PLAYER_WIDTH) - int'(BULLET_WIDTH)) / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic         fire = 1'b0;
    logic         alive = 1'b0;
    logic [9:0]   ppos = '0;
    logic [N-1:0] cmask = '1;

    int n_checks = 0;
    int n_fail = 0;

    // Model state, one set per DUT instance: [0] default cooldown, [1] cooldown 2.
    bit m_live[2][N];
    int m_x[2][N];
    int m_y[2][N];
    int m_cd[2];
    int m_cdload[2] = '{8, 2};

    player_bullet_controller_if #(.N(N)) bus0 ();
    player_bullet_controller_if #(.N(N)) bus1 ();

    assign bus0.i_FrameTick      = tick;
    assign bus0.i_Fire           = fire;
    assign bus0.i_PlayerState    = alive;
    assign bus0.i_PlayerPosition = ppos;
    assign bus0.i_CollidedState  = cmask;
    assign bus1.i_FrameTick      = tick;
    assign bus1.i_Fire           = fire;
    assign bus1.i_PlayerState    = alive;
    assign bus1.i_PlayerPosition = ppos;
    assign bus1.i_CollidedState  = cmask;

    player_bullet_controller #(.MAX_PLAYER_BULLET(N)) u_dut0 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus0.slave)
    );

    player_bullet_controller #(.MAX_PLAYER_BULLET(N), .FIRE_COOLDOWN(4'd2)) u_dut1 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cd[m] = 0;
            for (int i = 0; i < N; i++) begin
                m_live[m][i] = 0;
                m_x[m][i]    = 0;
                m_y[m][i]    = 0;
            end
        end
    endfunction

    function automatic bit model_frame(input int m, input bit f, input bit a, input int p,
                                       input logic [N-1:0] mask);
        bit spawned = 0;
        for (int i = 0; i < N; i++) if (!mask[i]) m_live[m][i] = 0;
        if (m_cd[m] > 0) m_cd[m]--;
        for (int i = 0; i < N; i++) begin
            if (m_live[m][i]) begin
                if (m_y[m][i] < 4) m_live[m][i] = 0;
                else               m_y[m][i] -= 4;
            end
        end
        if (f && a && m_cd[m] == 0) begin
            for (int i = 0; i < N; i++) begin
                if (!m_live[m][i]) begin
                    m_live[m][i] = 1;
                    m_x[m][i]    = p + X_OFF;
                    m_y[m][i]    = SPAWN_Y;
                    m_cd[m]      = m_cdload[m];
                    spawned      = 1;
                    break;
                end
            end
        end
        return spawned;
    endfunction

    function automatic logic [8:0] y_of(input logic [N*PW-1:0] v, input int i);
        return v[i*PW +: 9];
    endfunction

    function automatic logic [9:0] x_of(input logic [N*PW-1:0] v, input int i);
        return v[i*PW+9 +: 10];
    endfunction

    task automatic compare_all(input string tag);
        logic [N-1:0]    st;
        logic [N*PW-1:0] pv;
        logic [18:0]     exp_pos;
        for (int m = 0; m < 2; m++) begin
            st = (m == 0) ? bus0.o_PlayerBulletState : bus1.o_PlayerBulletState;
            pv = (m == 0) ? bus0.o_PlayerBulletPosition : bus1.o_PlayerBulletPosition;
            for (int i = 0; i < N; i++) begin
                exp_pos = m_live[m][i] ? {10'(m_x[m][i]), 9'(m_y[m][i])} : 19'h7FFFF;
                check($sformatf("%s_d%0d_st%0d", tag, m, i), 64'(st[i]), 64'(m_live[m][i]));
                check($sformatf("%s_d%0d_pos%0d", tag, m, i), 64'(pv[i*PW +: PW]), 64'(exp_pos));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_st0"}, 64'(bus0.o_PlayerBulletState), 64'(0));
        check({tag, "_st1"}, 64'(bus1.o_PlayerBulletState), 64'(0));
        check({tag, "_busy"}, 64'({bus0.o_Busy, bus1.o_Busy}), 64'(0));
        check({tag, "_fired"}, 64'({bus0.o_Fired, bus1.o_Fired}), 64'(0));
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_pos0_%0d", tag, i), 64'(bus0.o_PlayerBulletPosition[i]), 64'h7FFFF);
            check($sformatf("%s_pos1_%0d", tag, i), 64'(bus1.o_PlayerBulletPosition[i]), 64'h7FFFF);
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        tick  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
    endtask

    // One full frame: tick, 17 busy cycles with disturbances, then model update and compare.
    task automatic run_frame(input bit f, input bit a, input logic [9:0] p,
                             input logic [N-1:0] mask, output bit obs0, output bit obs1);
        int  busy_low = 0;
        int  fired_other = 0;
        bit  e0, e1;
        @(negedge clk);
        tick  = 1'b1;
        cmask = mask;
        fire  = 1'($urandom);
        alive = 1'($urandom);
        ppos  = 10'($urandom_range(0, 616));
        @(negedge clk);
        tick = 1'b0;
        obs0 = 0;
        obs1 = 0;
        for (int k = 1; k <= 17; k++) begin
            if (!bus0.o_Busy || !bus1.o_Busy) busy_low++;
            if (k == 17) begin
                obs0 = bus0.o_Fired;
                obs1 = bus1.o_Fired;
            end else begin
                fired_other += int'(bus0.o_Fired) + int'(bus1.o_Fired);
            end
            if (k == 2) cmask = N'($urandom);
            if (k == 5) tick = 1'b1;
            if (k == 6) tick = 1'b0;
            if (k == 16) begin
                fire  = f;
                alive = a;
                ppos  = p;
            end
            @(negedge clk);
        end
        check("busy_during_frame", 64'(busy_low), 64'(0));
        check("fired_outside_spawn", 64'(fired_other), 64'(0));
        check("busy_after_frame", 64'({bus0.o_Busy, bus1.o_Busy}), 64'(0));
        e0 = model_frame(0, f, a, int'(p), mask);
        e1 = model_frame(1, f, a, int'(p), mask);
        check("fired", 64'({obs0, obs1}), 64'({e0, e1}));
        compare_all("frame");
    endtask

    initial begin
        bit           o0, o1;
        int           busy_seen;
        logic [39:0]  fired_frames, exp_frames;
        logic [N-1:0] mask;

        model_reset();
        #12;
        check_reset_state("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.o_Busy || bus1.o_Busy) busy_seen++;
        end
        check("idle_no_tick_busy", 64'(busy_seen), 64'(0));
        check_reset_state("rst_idle");

        // First shot at x=100, then one frame of flight.
        run_frame(1, 1, 10'd100, '1, o0, o1);
        check("shot_fired17", 64'(o0), 64'(1));
        check("shot_x", 64'(x_of(bus0.o_PlayerBulletPosition, 0)), 64'(110));
        check("shot_y", 64'(y_of(bus0.o_PlayerBulletPosition, 0)), 64'(404));
        run_frame(0, 1, 10'd100, '1, o0, o1);
        check("shot_y_next", 64'(y_of(bus0.o_PlayerBulletPosition, 0)), 64'(400));

        // Fire held for 40 frames.
        reset_all();
        fired_frames = '0;
        for (int fr = 0; fr < 40; fr++) begin
            run_frame(1, 1, 10'd100, '1, o0, o1);
            fired_frames[fr] = o0;
        end
        exp_frames = '0;
        for (int fr = 0; fr < 40; fr++) exp_frames[fr] = (fr % 8 == 0);
        check("hold_spawn_frames", 64'(fired_frames), 64'(exp_frames));
        check("hold_slots", 64'(bus0.o_PlayerBulletState), 64'(15'h001F));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_dy%0d", i),
                  64'(int'(y_of(bus0.o_PlayerBulletPosition, i + 1)) -
                      int'(y_of(bus0.o_PlayerBulletPosition, i))), 64'(32));
        end

        // Single bullet lifetime and slot reuse.
        reset_all();
        run_frame(1, 1, 10'd300, '1, o0, o1);
        repeat (101) run_frame(0, 1, 10'd300, '1, o0, o1);
        check("life_y0_live", 64'(bus0.o_PlayerBulletState[0]), 64'(1));
        check("life_y0", 64'(y_of(bus0.o_PlayerBulletPosition, 0)), 64'(0));
        run_frame(0, 1, 10'd300, '1, o0, o1);
        check("life_retired", 64'(bus0.o_PlayerBulletState[0]), 64'(0));
        check("life_none", 64'(bus0.o_PlayerBulletPosition[0]), 64'h7FFFF);
        run_frame(1, 1, 10'd50, '1, o0, o1);
        check("life_reuse", 64'({bus0.o_PlayerBulletState[0], y_of(bus0.o_PlayerBulletPosition, 0)}),
              64'({1'b1, 9'd404}));

        // Collision feedback on slots 0..3.
        reset_all();
        repeat (25) run_frame(1, 1, 10'd200, '1, o0, o1);
        mask = {11'h7FF, 4'b1010};
        run_frame(0, 1, 10'd200, mask, o0, o1);
        check("coll_state", 64'(bus0.o_PlayerBulletState), 64'(15'b1010));
        check("coll_none0", 64'(bus0.o_PlayerBulletPosition[0]), 64'h7FFFF);
        check("coll_none2", 64'(bus0.o_PlayerBulletPosition[2]), 64'h7FFFF);
        check("coll_y1", 64'(y_of(bus0.o_PlayerBulletPosition, 1)), 64'(336));
        check("coll_y3", 64'(y_of(bus0.o_PlayerBulletPosition, 3)), 64'(400));

        // Full pool on the short-cooldown instance.
        reset_all();
        repeat (29) run_frame(1, 1, 10'd10, '1, o0, o1);
        check("full_state", 64'(bus1.o_PlayerBulletState), 64'(15'h7FFF));
        run_frame(1, 1, 10'd10, '1, o0, o1);
        run_frame(1, 1, 10'd10, '1, o0, o1);
        check("full_no_fire", 64'(o1), 64'(0));
        run_frame(1, 1, 10'd10, {{(N-1){1'b1}}, 1'b0}, o0, o1);
        check("full_cd_not_loaded", 64'(o1), 64'(1));
        check("full_refill_y", 64'(y_of(bus1.o_PlayerBulletPosition, 0)), 64'(404));

        // Dead player cannot fire.
        reset_all();
        run_frame(1, 0, 10'd200, '1, o0, o1);
        check("dead_no_fire", 64'({o0, bus0.o_PlayerBulletState[0]}), 64'(0));
        run_frame(1, 1, 10'd200, '1, o0, o1);
        check("alive_fire", 64'(o0), 64'(1));

        // Reset during MOVE index 7 (cycle 9 after the tick edge).
        run_frame(0, 1, 10'd0, '1, o0, o1);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        check_reset_state("rst_mid_after");
        run_frame(1, 1, 10'd400, '1, o0, o1);

        // Randomised frames.
        for (int fr = 0; fr < 150; fr++) begin
            mask = ~(N'($urandom) & N'($urandom) & N'($urandom));
            run_frame(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                      10'($urandom_range(0, 616)), mask, o0, o1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
